// File: rtl/harvest_pkg.sv
// Shared types, default timing constants and width helper for the harvest sequencer.
package harvest_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CONVERT = 2'd2,
        PUSH    = 2'd3
    } state_t;

    localparam int unsigned DEF_NUM_CH      = 4;
    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_SETTLE_CYC  = 4;
    localparam int unsigned DEF_PERIOD_CYC  = 64;
    localparam int unsigned DEF_TIMEOUT_CYC = 16;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/harvest_sequencer_rr_next_channel.sv
// Picks the next enabled channel strictly above the current one, or the lowest one on start.
module rr_next_channel #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [CH_W-1:0]   i_cur,
    input  logic              i_start,
    output logic [CH_W-1:0]   o_next,
    output logic              o_none
);

    // Scan downward so the lowest qualifying bit is the one left standing.
    always_comb begin
        o_next = '0;
        o_none = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_mask[i] && (i_start || (i > int'(i_cur)))) begin
                o_next = CH_W'(i);
                o_none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/harvest_sequencer.sv
// Periodic sweep scheduler sharing one converter between NUM_CH harvesting sources.
module harvest_sequencer
    import harvest_pkg::*;
#(
    parameter int unsigned NUM_CH      = DEF_NUM_CH,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int unsigned PERIOD_CYC  = DEF_PERIOD_CYC,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int unsigned CH_W       = idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_enable,
    output logic [CH_W-1:0]   ch_sel,
    output logic              conv_start,
    input  logic              conv_done,
    input  logic [DATA_W-1:0] conv_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_err,
    output logic              busy,
    output logic [7:0]        overrun_cnt
);

    localparam int unsigned PER_W = idx_w(PERIOD_CYC);
    localparam int unsigned SET_W = idx_w(SETTLE_CYC);
    localparam int unsigned TMO_W = idx_w(TIMEOUT_CYC);

    state_t              r_state;
    logic [PER_W-1:0]    r_period_cnt;
    logic [SET_W-1:0]    r_settle_cnt;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic [NUM_CH-1:0]   r_mask_q;

    state_t              w_state_nxt;
    logic [SET_W-1:0]    w_settle_nxt;
    logic [TMO_W-1:0]    w_tmo_nxt;
    logic [NUM_CH-1:0]   w_mask_nxt;
    logic [CH_W-1:0]     w_ch_sel_nxt;
    logic                w_conv_start_nxt;
    logic                w_out_valid_nxt;
    logic [DATA_W-1:0]   w_out_data_nxt;
    logic [CH_W-1:0]     w_out_ch_nxt;
    logic                w_out_err_nxt;
    logic                w_busy_nxt;

    logic                w_tick;
    logic                w_idle;
    logic [NUM_CH-1:0]   w_rr_mask;
    logic [CH_W-1:0]     w_rr_next;
    logic                w_rr_none;

    assign w_tick    = en && (r_period_cnt == PER_W'(PERIOD_CYC - 1));
    assign w_idle    = (r_state == IDLE);
    assign w_rr_mask = w_idle ? ch_enable : r_mask_q;

    rr_next_channel #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr (
        .i_mask  (w_rr_mask),
        .i_cur   (ch_sel),
        .i_start (w_idle),
        .o_next  (w_rr_next),
        .o_none  (w_rr_none)
    );

    // Free-running sweep period counter, parked at zero while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period_cnt <= '0;
        end else if (!en || w_tick) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + PER_W'(1);
        end
    end

    // Ticks that arrive mid-sweep are dropped and counted, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_cnt <= '0;
        end else if (w_tick && busy && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

    // Next-state and next-output logic for the sweep FSM.
    always_comb begin
        w_state_nxt      = r_state;
        w_settle_nxt     = r_settle_cnt;
        w_tmo_nxt        = r_tmo_cnt;
        w_mask_nxt       = r_mask_q;
        w_ch_sel_nxt     = ch_sel;
        w_conv_start_nxt = 1'b0;
        w_out_valid_nxt  = out_valid;
        w_out_data_nxt   = out_data;
        w_out_ch_nxt     = out_ch;
        w_out_err_nxt    = out_err;
        w_busy_nxt       = busy;

        case (r_state)
            IDLE: begin
                if (w_tick && (ch_enable != '0)) begin
                    w_mask_nxt   = ch_enable;
                    w_ch_sel_nxt = w_rr_next;
                    w_settle_nxt = '0;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = SETTLE;
                end
            end
            SETTLE: begin
                if (!en) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else if (r_settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
                    w_conv_start_nxt = 1'b1;
                    w_tmo_nxt        = '0;
                    w_state_nxt      = CONVERT;
                end else begin
                    w_settle_nxt = r_settle_cnt + SET_W'(1);
                end
            end
            CONVERT: begin
                if (!en) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else if (conv_done) begin
                    w_out_data_nxt  = conv_data;
                    w_out_err_nxt   = 1'b0;
                    w_out_ch_nxt    = ch_sel;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = PUSH;
                end else if (!conv_start) begin
                    // Timeout window opens the cycle after the start strobe.
                    if (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        w_out_data_nxt  = '0;
                        w_out_err_nxt   = 1'b1;
                        w_out_ch_nxt    = ch_sel;
                        w_out_valid_nxt = 1'b1;
                        w_state_nxt     = PUSH;
                    end else begin
                        w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
                    end
                end
            end
            PUSH: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    if (en && !w_rr_none) begin
                        w_ch_sel_nxt = w_rr_next;
                        w_settle_nxt = '0;
                        w_state_nxt  = SETTLE;
                    end else begin
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_settle_cnt <= '0;
            r_tmo_cnt    <= '0;
            r_mask_q     <= '0;
            ch_sel       <= '0;
            conv_start   <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_ch       <= '0;
            out_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_tmo_cnt    <= w_tmo_nxt;
            r_mask_q     <= w_mask_nxt;
            ch_sel       <= w_ch_sel_nxt;
            conv_start   <= w_conv_start_nxt;
            out_valid    <= w_out_valid_nxt;
            out_data     <= w_out_data_nxt;
            out_ch       <= w_out_ch_nxt;
            out_err      <= w_out_err_nxt;
            busy         <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_harvest_sequencer.sv
// Directed self-checking bench for harvest_sequencer (PERIOD_CYC=8 build).
module tb_harvest_sequencer;

    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned SETTLE_CYC  = 4;
    localparam int unsigned PERIOD_CYC  = 8;
    localparam int unsigned TIMEOUT_CYC = 16;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              en        = 1'b0;
    logic [NUM_CH-1:0] ch_enable = '0;
    logic [1:0]        ch_sel;
    logic              conv_start;
    logic              conv_done;
    logic [DATA_W-1:0] conv_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_ch;
    logic              out_err;
    logic              busy;
    logic [7:0]        overrun_cnt;

    logic              auto_conv = 1'b0;
    logic              man_done  = 1'b0;
    logic [7:0]        man_data  = 8'h00;
    logic              m_pend    = 1'b0;
    logic              m_done    = 1'b0;
    logic [7:0]        m_data    = 8'h00;
    logic [1:0]        m_idx     = 2'd0;
    logic [7:0]        data_tbl [0:3];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    assign conv_done = auto_conv ? m_done : man_done;
    assign conv_data = auto_conv ? m_data : man_data;

    harvest_sequencer #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .SETTLE_CYC  (SETTLE_CYC),
        .PERIOD_CYC  (PERIOD_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ch_enable   (ch_enable),
        .ch_sel      (ch_sel),
        .conv_start  (conv_start),
        .conv_done   (conv_done),
        .conv_data   (conv_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_err     (out_err),
        .busy        (busy),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Converter model: conv_done one cycle after conv_start, data taken from data_tbl in order.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                m_pend = 1'b0; m_done = 1'b0; m_data = 8'h00; m_idx = 2'd0;
            end else begin
                m_done = m_pend;
                m_data = m_pend ? data_tbl[m_idx] : 8'h00;
                if (m_pend) m_idx = m_idx + 2'd1;
                m_pend = auto_conv && conv_start;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; ch_enable = '0; out_ready = 1'b0;
        auto_conv = 1'b0; man_done = 1'b0; man_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({ch_sel, conv_start, out_valid, out_data, out_ch, out_err, busy, overrun_cnt} !== 23'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, expected 0",
                     {ch_sel, conv_start, out_valid, out_data, out_ch, out_err, busy, overrun_cnt});
        end
        do_reset();
        n_vec++;
        if (dut.r_state !== harvest_pkg::IDLE || dut.r_period_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL reset_state: got state %0d cnt %0d, expected 0 0", dut.r_state, dut.r_period_cnt);
        end
    endtask

    task automatic test_sweep();
        int t0;
        int n_push;
        int p_cyc [3];
        logic [1:0] p_ch [3];
        logic [7:0] p_d [3];
        logic       p_e [3];
        logic [1:0] exp_ch [3];
        logic [7:0] exp_d [3];
        exp_ch = '{2'd0, 2'd1, 2'd3};
        exp_d  = '{8'h3C, 8'h5A, 8'hC3};
        do_reset();
        data_tbl[0] = 8'h3C; data_tbl[1] = 8'h5A; data_tbl[2] = 8'hC3; data_tbl[3] = 8'h00;
        auto_conv = 1'b1; out_ready = 1'b1; ch_enable = 4'b1011; en = 1'b1;
        t0 = cyc; n_push = 0;
        for (int k = 0; k < 120 && n_push < 3; k++) begin
            @(posedge clk); #1;
            if (out_valid && out_ready) begin
                p_cyc[n_push] = cyc - t0;
                p_ch[n_push]  = out_ch;
                p_d[n_push]   = out_data;
                p_e[n_push]   = out_err;
                n_push++;
                ch_enable = 4'b0100;
            end
        end
        n_vec++;
        if (n_push != 3) begin
            n_err++; $display("FAIL sweep_push_count: got %0d, expected 3", n_push);
        end
        n_vec++;
        if (p_cyc[0] != 14) begin
            n_err++; $display("FAIL sweep_first_latency: got %0d, expected 14", p_cyc[0]);
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({p_ch[i], p_d[i], p_e[i]} !== {exp_ch[i], exp_d[i], 1'b0}) begin
                n_err++;
                $display("FAIL sweep_push%0d: got ch %0d data %h err %b, expected ch %0d data %h err 0",
                         i, p_ch[i], p_d[i], p_e[i], exp_ch[i], exp_d[i]);
            end
        end
        n_vec++;
        if ((p_cyc[1] - p_cyc[0] != 7) || (p_cyc[2] - p_cyc[1] != 7)) begin
            n_err++;
            $display("FAIL sweep_per_channel: got %0d %0d, expected 7 7",
                     p_cyc[1] - p_cyc[0], p_cyc[2] - p_cyc[1]);
        end
        @(posedge clk); #1;
        en = 1'b0;
        n_vec++;
        if ({busy, out_valid} !== 2'b00) begin
            n_err++; $display("FAIL sweep_end_idle: got busy %b valid %b, expected 0 0", busy, out_valid);
        end
        n_vec++;
        if (overrun_cnt !== 8'd2) begin
            n_err++; $display("FAIL sweep_overrun: got %0d, expected 2", overrun_cnt);
        end
    endtask

    task automatic test_timeout();
        int t_cs;
        int t_ov;
        do_reset();
        auto_conv = 1'b0; out_ready = 1'b1; ch_enable = 4'b0100; en = 1'b1;
        t_cs = -1; t_ov = -1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (conv_start) begin t_cs = cyc; break; end
        end
        n_vec++;
        if (t_cs < 0 || ch_sel !== 2'd2) begin
            n_err++; $display("FAIL timeout_start: got start@%0d ch_sel %0d, expected start on ch 2", t_cs, ch_sel);
        end
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin t_ov = cyc; break; end
        end
        n_vec++;
        if (t_ov - t_cs != 17) begin
            n_err++; $display("FAIL timeout_latency: got %0d, expected 17", t_ov - t_cs);
        end
        n_vec++;
        if ({out_ch, out_data, out_err} !== {2'd2, 8'h00, 1'b1}) begin
            n_err++;
            $display("FAIL timeout_payload: got ch %0d data %h err %b, expected ch 2 data 00 err 1",
                     out_ch, out_data, out_err);
        end
        en = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL timeout_valid_drop: got %b, expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic found;
        do_reset();
        data_tbl[0] = 8'hA5;
        auto_conv = 1'b1; out_ready = 1'b0; ch_enable = 4'b0001; en = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin found = 1'b1; break; end
        end
        n_vec++;
        if (found !== 1'b1) begin
            n_err++; $display("FAIL bp_valid_seen: got %b, expected 1", found);
        end
        for (int k = 0; k < 10; k++) begin
            n_vec++;
            if ({out_valid, out_data, out_ch, out_err} !== {1'b1, 8'hA5, 2'd0, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold%0d: got valid %b data %h ch %0d err %b, expected 1 a5 0 0",
                         k, out_valid, out_data, out_ch, out_err);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_still_valid: got %b, expected 1", out_valid);
        end
        @(posedge clk); #1;
        en = 1'b0;
        n_vec++;
        if ({out_valid, busy} !== 2'b00) begin
            n_err++; $display("FAIL bp_transfer: got valid %b busy %b, expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        data_tbl[0] = 8'h11;
        auto_conv = 1'b1; out_ready = 1'b0; ch_enable = 4'b0001; en = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, overrun_cnt} !== {1'b1, 8'd4}) begin
            n_err++; $display("FAIL overrun_40: got busy %b cnt %0d, expected 1 4", busy, overrun_cnt);
        end
        repeat (8) @(posedge clk);
        #1;
        n_vec++;
        if (overrun_cnt !== 8'd5) begin
            n_err++; $display("FAIL overrun_step: got %0d, expected 5", overrun_cnt);
        end
        repeat (300 * 8) @(posedge clk);
        #1;
        n_vec++;
        if (overrun_cnt !== 8'd255) begin
            n_err++; $display("FAIL overrun_saturate: got %0d, expected 255", overrun_cnt);
        end
    endtask

    task automatic test_en_drop();
        logic found;
        logic seen;
        int   t0;
        int   t_b;
        do_reset();
        data_tbl[0] = 8'h22;
        auto_conv = 1'b1; out_ready = 1'b1; ch_enable = 4'b0110; en = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (busy) begin found = 1'b1; break; end
        end
        n_vec++;
        if (found !== 1'b1 || ch_sel !== 2'd1 || dut.r_state !== harvest_pkg::SETTLE) begin
            n_err++;
            $display("FAIL endrop_settle: got busy %b ch_sel %0d state %0d, expected 1 1 1",
                     found, ch_sel, dut.r_state);
        end
        en = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b0 || dut.r_state !== harvest_pkg::IDLE || dut.r_period_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL endrop_idle: got busy %b state %0d cnt %0d, expected 0 0 0",
                     busy, dut.r_state, dut.r_period_cnt);
        end
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (conv_start || busy) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL endrop_quiet: got activity %b, expected 0", seen);
        end
        ch_enable = 4'b0011; en = 1'b1;
        t0 = cyc; t_b = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (busy) begin t_b = cyc - t0; break; end
        end
        n_vec++;
        if (t_b != 8 || ch_sel !== 2'd0) begin
            n_err++; $display("FAIL endrop_restart: got delay %0d ch_sel %0d, expected 8 0", t_b, ch_sel);
        end
        en = 1'b0;
    endtask

    task automatic test_async_rst();
        logic found;
        logic seen;
        do_reset();
        auto_conv = 1'b0; out_ready = 1'b1; ch_enable = 4'b0100; en = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (conv_start) begin found = 1'b1; break; end
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_vec++;
        if ({found, busy, ch_sel} !== {1'b1, 1'b1, 2'd2}) begin
            n_err++; $display("FAIL arst_pre: got start %b busy %b ch_sel %0d, expected 1 1 2", found, busy, ch_sel);
        end
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if ({ch_sel, conv_start, out_valid, out_data, out_ch, out_err, busy, overrun_cnt} !== 23'd0) begin
            n_err++;
            $display("FAIL arst_outputs: got %h, expected 0",
                     {ch_sel, conv_start, out_valid, out_data, out_ch, out_err, busy, overrun_cnt});
        end
        man_done = 1'b1; man_data = 8'h77;
        @(posedge clk); #1 rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen = 1'b1;
        end
        man_done = 1'b0;
        en = 1'b0;
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL arst_no_push: got activity %b, expected 0", seen);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sweep();
        test_timeout();
        test_backpressure();
        test_overrun();
        test_en_drop();
        test_async_rst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
